// File: rtl/dl_rom_sequencer.sv
// Download-to-ROM sequencer: splits the HPS byte stream into four ROM regions, hands each
// byte to the ROM port through a one-entry valid/ready buffer and gates the core reset.
module dl_rom_sequencer #(
    parameter int unsigned ROM_SIZE    = 37120,
    parameter int unsigned REG1_BASE   = 24576,
    parameter int unsigned REG2_BASE   = 32768,
    parameter int unsigned REG3_BASE   = 36864,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        dn_ready,
    output logic        dn_wr,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic [1:0]  dn_region,
    output logic        core_reset,
    output logic        dl_busy,
    output logic        dl_done,
    output logic        dl_error,
    output logic [16:0] byte_count,
    output logic [7:0]  checksum
);

    localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

    localparam logic [24:0] RomEnd = 25'(ROM_SIZE);
    localparam logic [24:0] Reg1Hi = 25'(REG1_BASE);
    localparam logic [24:0] Reg2Hi = 25'(REG2_BASE);
    localparam logic [24:0] Reg3Hi = 25'(REG3_BASE);
    localparam logic [15:0] Reg1Lo = 16'(REG1_BASE);
    localparam logic [15:0] Reg2Lo = 16'(REG2_BASE);
    localparam logic [15:0] Reg3Lo = 16'(REG3_BASE);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StDrain,
        StHold,
        StRun
    } state_e;

    state_e             state_q, state_d;
    logic [HoldW-1:0]   hold_q;
    logic               dn_wr_q;
    logic [15:0]        dn_addr_q;
    logic [7:0]         dn_data_q;
    logic [1:0]         dn_region_q;
    logic               core_reset_q;
    logic               dl_busy_q;
    logic               dl_done_q;
    logic               dl_error_q;
    logic [16:0]        byte_count_q;
    logic [7:0]         checksum_q;

    logic               xfer;
    logic               in_range;
    logic               load_entry;
    logic               cap_req;
    logic               accept;
    logic               overrun;
    logic               image_ok;
    logic [1:0]         cap_region;
    logic [15:0]        cap_base;
    logic [15:0]        cap_offset;

    always_comb begin
        xfer       = dn_wr_q & dn_ready;
        in_range   = ioctl_addr < RomEnd;
        load_entry = ioctl_download &&
                     (state_q == StIdle || state_q == StHold || state_q == StRun);
        // A byte arriving on the same edge that opens the window is still captured.
        cap_req    = (state_q == StLoad || load_entry) && ioctl_wr && in_range;
        accept     = cap_req && (!dn_wr_q || dn_ready);
        overrun    = cap_req && !accept;
        image_ok   = (byte_count_q == 17'(ROM_SIZE)) && !dl_error_q;

        if (ioctl_addr < Reg1Hi) begin
            cap_region = 2'd0;
            cap_base   = 16'd0;
        end else if (ioctl_addr < Reg2Hi) begin
            cap_region = 2'd1;
            cap_base   = Reg1Lo;
        end else if (ioctl_addr < Reg3Hi) begin
            cap_region = 2'd2;
            cap_base   = Reg2Lo;
        end else begin
            cap_region = 2'd3;
            cap_base   = Reg3Lo;
        end
        cap_offset = ioctl_addr[15:0] - cap_base;

        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ioctl_download) state_d = StLoad;
            StLoad:  if (!ioctl_download) state_d = StDrain;
            StDrain: if (!dn_wr_q || xfer) state_d = StHold;
            StHold: begin
                if (ioctl_download) begin
                    state_d = StLoad;
                end else if (hold_q <= HoldW'(1)) begin
                    state_d = image_ok ? StRun : StIdle;
                end
            end
            StRun:   if (ioctl_download) state_d = StLoad;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= StIdle;
            hold_q       <= '0;
            dn_wr_q      <= 1'b0;
            dn_addr_q    <= '0;
            dn_data_q    <= '0;
            dn_region_q  <= '0;
            core_reset_q <= 1'b1;
            dl_busy_q    <= 1'b0;
            dl_done_q    <= 1'b0;
            dl_error_q   <= 1'b0;
            byte_count_q <= '0;
            checksum_q   <= '0;
        end else begin
            state_q      <= state_d;
            core_reset_q <= (state_d != StRun);
            dl_done_q    <= (state_d == StRun);
            dl_busy_q    <= (state_d == StLoad) || (state_d == StDrain) ||
                            (state_d == StHold);

            // Counts HOLD_CYCLES cycles of HOLD before the release decision.
            if (state_q == StDrain && state_d == StHold) begin
                hold_q <= HoldW'(HOLD_CYCLES);
            end else if (state_q == StHold && hold_q != '0) begin
                hold_q <= hold_q - HoldW'(1);
            end

            if (accept) begin
                dn_wr_q     <= 1'b1;
                dn_addr_q   <= cap_offset;
                dn_data_q   <= ioctl_dout;
                dn_region_q <= cap_region;
            end else if (xfer) begin
                dn_wr_q     <= 1'b0;
            end

            if (load_entry) begin
                byte_count_q <= accept ? 17'd1 : 17'd0;
                checksum_q   <= accept ? ioctl_dout : 8'd0;
                dl_error_q   <= 1'b0;
            end else begin
                if (accept) begin
                    byte_count_q <= byte_count_q + 17'd1;
                    checksum_q   <= checksum_q + ioctl_dout;
                end
                if (overrun) begin
                    dl_error_q <= 1'b1;
                end
            end
        end
    end

    assign dn_wr      = dn_wr_q;
    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign dn_region  = dn_region_q;
    assign core_reset = core_reset_q;
    assign dl_busy    = dl_busy_q;
    assign dl_done    = dl_done_q;
    assign dl_error   = dl_error_q;
    assign byte_count = byte_count_q;
    assign checksum   = checksum_q;

endmodule

// File: doc/dl_rom_sequencer.md
Name: dl_rom_sequencer

Overview:
- Sits between the HPS download stream (ioctl_*) and the arcade core's ROM write port (dn_*).
- Splits the linear download into four ROM regions and emits region-relative addresses.
- Buffers each byte in a one-entry holding register and hands it to the ROM port with a valid/ready handshake.
- Holds the core in reset until a complete, error-free image has landed, then releases it after a settle period.

Parameters:
- ROM_SIZE, 37120 (0x9100): total expected image bytes. Addresses >= ROM_SIZE are ignored. Range 1..65536.
- REG1_BASE, 24576 (0x6000): first address of region 1.
- REG2_BASE, 32768 (0x8000): first address of region 2.
- REG3_BASE, 36864 (0x9000): first address of region 3. Requires 0 < REG1_BASE < REG2_BASE < REG3_BASE < ROM_SIZE.
- HOLD_CYCLES, 16: settle cycles between the last ROM write and core reset release. Must be >= 1.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous active-high reset
- ioctl_download  in  1  download window active
- ioctl_wr  in  1  single-cycle byte strobe
- ioctl_addr  in  25  byte address within the image
- ioctl_dout  in  8  byte data
- dn_ready  in  1  ROM port accepts the byte this cycle
- dn_wr  out  1  byte valid to the ROM port
- dn_addr  out  16  address relative to the selected region's base
- dn_data  out  8  byte data
- dn_region  out  2  region select, 0..3
- core_reset  out  1  active-high reset to the core
- dl_busy  out  1  high in states LOAD, DRAIN and HOLD
- dl_done  out  1  high in state RUN
- dl_error  out  1  sticky overrun flag
- byte_count  out  17  in-range bytes captured
- checksum  out  8  mod-256 sum of captured bytes

Behaviour:
- Clock and reset: single clock clk_sys; reset is synchronous and active-high.
- Values on reset:
  - State = IDLE.
  - core_reset = 1.
  - dn_wr = 0, dn_addr = 0, dn_data = 0, dn_region = 0.
  - dl_busy = 0, dl_done = 0, dl_error = 0.
  - byte_count = 0, checksum = 0.
  - Any pending byte is discarded.
  - Reset during LOAD, DRAIN or HOLD aborts the operation with no further dn_wr.
- Derived outputs:
  - core_reset = (state != RUN).
  - dl_done = (state == RUN).
  - All outputs are registered.
- State IDLE -> LOAD when ioctl_download = 1. Entry to LOAD from any state clears byte_count, checksum and dl_error.
- State LOAD, capture:
  - A byte is captured when ioctl_wr = 1 and ioctl_addr < ROM_SIZE.
  - Capture latches dn_data, dn_region and dn_addr, and sets dn_wr = 1 on the next cycle (1-cycle latency).
  - byte_count increments and checksum += ioctl_dout in the same edge.
- Region decode, on the capture address:
  - addr < REG1_BASE: region 0, offset = addr.
  - addr < REG2_BASE: region 1, offset = addr - REG1_BASE.
  - addr < REG3_BASE: region 2, offset = addr - REG2_BASE.
  - Otherwise: region 3, offset = addr - REG3_BASE.
  - Offsets are truncated to 16 bits.
- ROM port handshake:
  - A transfer completes on a cycle with dn_wr & dn_ready.
  - dn_wr, dn_addr, dn_data and dn_region stay stable until that transfer.
  - dn_wr drops the next cycle unless a new byte was captured on the transfer cycle. In that case dn_wr stays 1 with the new byte (back-to-back allowed).
- Overrun: ioctl_wr in range while dn_wr = 1 and dn_ready = 0.
  - The new byte is dropped and not counted.
  - dl_error is set; it is sticky until the next LOAD entry or reset.
- Out-of-range writes (addr >= ROM_SIZE) are silently ignored: no count, no error.
- LOAD -> DRAIN when ioctl_download falls.
- DRAIN:
  - Waits until the pending byte transfers.
  - An ioctl_wr arriving in DRAIN is ignored.
  - Then -> HOLD, with the hold counter loaded to HOLD_CYCLES.
- HOLD:
  - The counter decrements every cycle.
  - At 0: if byte_count == ROM_SIZE and dl_error = 0, go to RUN; otherwise go to IDLE.
  - ioctl_download = 1 during HOLD restarts LOAD.
- RUN: ioctl_download = 1 -> LOAD. core_reset rises on the same edge.
- Simultaneous ioctl_download rise and ioctl_wr in IDLE or RUN: the byte is captured, with LOAD entry and capture on the same edge.

Test Plan:
1. Full load, dn_ready tied 1, ROM_SIZE bytes of value 0x01 with ioctl_wr every 4 cycles:
   - ROM port sees 37120 dn_wr pulses; byte_count = 37120; checksum = 0x00.
   - core_reset falls exactly 16 cycles after the last transfer; dl_done = 1.
2. Region split: write addresses 0x5FFF, 0x6000, 0x8001 and 0x9005:
   - dn_region/dn_addr = 0/0x5FFF, 1/0x0000, 2/0x0001, 3/0x0005.
   - Each dn_wr asserts 1 cycle after its ioctl_wr.
3. Backpressure:
   - dn_ready low for 3 cycles while dn_wr is high: outputs stay stable.
   - A second ioctl_wr during the stall: dl_error = 1, byte_count not incremented.
   - After download falls: state returns to IDLE and core_reset stays 1.
4. Short image: download ends after 100 bytes -> after HOLD, IDLE; core_reset = 1; dl_done = 0.
5. Reload from RUN:
   - ioctl_download rises: core_reset = 1 on the next cycle; byte_count, checksum and dl_error cleared.
   - A full reload returns the block to RUN.
6. Reset mid-LOAD with dn_wr pending: next cycle dn_wr = 0, byte_count = 0, state IDLE; no dn_wr afterwards without a new download.
